// File: rtl/riscv32ima_lsu.sv
// Load/store stage of the riscv32ima pipeline: runs one data-memory access at a time,
// aligns/extends load data, builds store strobes, and registers everything else through.
module riscv32ima_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int OPCODE_WIDTH   = 7,
    parameter int FUNC3_WIDTH    = 3,
    parameter logic [OPCODE_WIDTH-1:0] LOAD  = 7'b0000011,
    parameter logic [OPCODE_WIDTH-1:0] STORE = 7'b0100011
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      exe_valid,
    output logic                      exe_ready,
    input  logic [OPCODE_WIDTH-1:0]   exe_opcode,
    input  logic [FUNC3_WIDTH-1:0]    exe_func3,
    input  logic [REG_ADDR_WIDTH-1:0] exe_reg_addr,
    input  logic [REG_DATA_WIDTH-1:0] exe_result,
    input  logic [REG_DATA_WIDTH-1:0] exe_rs2,
    output logic                      dmem_valid,
    input  logic                      dmem_ready,
    output logic                      dmem_wen,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [3:0]                dmem_wstrb,
    output logic [REG_DATA_WIDTH-1:0] dmem_wdata,
    input  logic                      dmem_rvalid,
    input  logic [REG_DATA_WIDTH-1:0] dmem_rdata,
    output logic                      lsu_valid,
    input  logic                      lsu_ready,
    output logic [OPCODE_WIDTH-1:0]   lsu_opcode,
    output logic [REG_ADDR_WIDTH-1:0] lsu_reg_addr,
    output logic [REG_DATA_WIDTH-1:0] lsu_mem_addr,
    output logic [REG_DATA_WIDTH-1:0] lsu_data,
    output logic                      lsu_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t                    state;
    logic [FUNC3_WIDTH-1:0]    func3;
    logic                      accept;
    logic                      is_store;
    logic                      is_mem;
    logic                      aligned;
    logic [3:0]                strb;
    logic [REG_DATA_WIDTH-1:0] wdata;
    logic [REG_DATA_WIDTH-1:0] shifted;
    logic [REG_DATA_WIDTH-1:0] load_data;

    assign exe_ready = (state == IDLE) || (state == OUT && lsu_ready);
    assign accept    = exe_valid && exe_ready;
    assign is_store  = (exe_opcode == STORE);
    assign is_mem    = (exe_opcode == LOAD) || is_store;

    // Alignment, strobe and lane-replicated store data from the incoming instruction
    always_comb begin
        aligned = 1'b0;
        strb    = 4'b1111;
        wdata   = exe_rs2;
        case (exe_func3[1:0])
            2'b00: begin
                aligned = 1'b1;
                strb    = 4'b0001 << exe_result[1:0];
                wdata   = {4{exe_rs2[7:0]}};
            end
            2'b01: begin
                aligned = !exe_result[0];
                strb    = 4'b0011 << exe_result[1:0];
                wdata   = {2{exe_rs2[15:0]}};
            end
            2'b10:   aligned = (exe_result[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign shifted = dmem_rdata >> {lsu_mem_addr[1:0], 3'b000};

    always_comb begin
        case (func3)
            3'b000:  load_data = {{(REG_DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {{(REG_DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b001:  load_data = {{(REG_DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {{(REG_DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= IDLE;
            func3        <= '0;
            dmem_valid   <= 1'b0;
            dmem_wen     <= 1'b0;
            dmem_addr    <= '0;
            dmem_wstrb   <= '0;
            dmem_wdata   <= '0;
            lsu_valid    <= 1'b0;
            lsu_opcode   <= '0;
            lsu_reg_addr <= '0;
            lsu_mem_addr <= '0;
            lsu_data     <= '0;
            lsu_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE, OUT: begin
                    // OUT with lsu_ready doubles as IDLE so pass-through runs back to back
                    if (accept) begin
                        func3        <= exe_func3;
                        lsu_opcode   <= exe_opcode;
                        lsu_reg_addr <= exe_reg_addr;
                        lsu_mem_addr <= exe_result;
                        lsu_fault    <= 1'b0;
                        if (is_mem && aligned) begin
                            state      <= REQ;
                            lsu_valid  <= 1'b0;
                            lsu_data   <= exe_result;
                            dmem_valid <= 1'b1;
                            dmem_wen   <= is_store;
                            dmem_addr  <= {exe_result[ADDR_WIDTH-1:2], 2'b00};
                            dmem_wstrb <= is_store ? strb : 4'b0000;
                            dmem_wdata <= wdata;
                        end else begin
                            state     <= OUT;
                            lsu_valid <= 1'b1;
                            lsu_fault <= is_mem;
                            lsu_data  <= is_mem ? '0 : exe_result;
                        end
                    end else if (state == OUT && lsu_ready) begin
                        state     <= IDLE;
                        lsu_valid <= 1'b0;
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        dmem_valid <= 1'b0;
                        dmem_wen   <= 1'b0;
                        dmem_wstrb <= '0;
                        if (dmem_wen) begin
                            state     <= OUT;
                            lsu_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state     <= OUT;
                        lsu_valid <= 1'b1;
                        lsu_data  <= load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv32ima_lsu.sv
// Self-checking bench for riscv32ima_lsu: directed table, randomized instructions against
// a transaction-level model, and hand-written reset/backpressure sequences.
module tb_riscv32ima_lsu;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        exe_valid = 1'b0;
    logic        exe_ready;
    logic [6:0]  exe_opcode = '0;
    logic [2:0]  exe_func3 = '0;
    logic [4:0]  exe_reg_addr = '0;
    logic [31:0] exe_result = '0;
    logic [31:0] exe_rs2 = '0;
    logic        dmem_valid;
    logic        dmem_ready = 1'b0;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        lsu_valid;
    logic        lsu_ready = 1'b0;
    logic [6:0]  lsu_opcode;
    logic [4:0]  lsu_reg_addr;
    logic [31:0] lsu_mem_addr;
    logic [31:0] lsu_data;
    logic        lsu_fault;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    riscv32ima_lsu #(
        .ADDR_WIDTH(32),
        .REG_DATA_WIDTH(32)
    ) dut (
        .clk(clk), .nrst(nrst),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_opcode(exe_opcode),
        .exe_func3(exe_func3), .exe_reg_addr(exe_reg_addr), .exe_result(exe_result),
        .exe_rs2(exe_rs2),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_wen(dmem_wen),
        .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_opcode(lsu_opcode),
        .lsu_reg_addr(lsu_reg_addr), .lsu_mem_addr(lsu_mem_addr), .lsu_data(lsu_data),
        .lsu_fault(lsu_fault)
    );

    typedef struct {
        logic        mem;
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          dr;
        exp_t        e;
    } vec_t;

    typedef struct {
        bit          req_seen;
        int          req_cyc;
        int          req_cnt;
        bit          req_stable;
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          lsu_seen;
        int          lsu_cyc;
        bit          lsu_stable;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] mem_addr;
        logic [31:0] data;
        logic        fault;
        bit          done;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: what one instruction should do, computed from sizes and byte offsets.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] res, input logic [31:0] rs2,
                                   input logic [31:0] rdata);
        exp_t   e;
        int     size;
        int     off;
        longint v;
        longint span;
        e = '{default: 0};
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(res % 4);
        if (op != LOAD && op != STORE) begin
            e.data = res;
            return e;
        end
        if (f3[1:0] == 2'b11 || (off % size) != 0) begin
            e.fault = 1'b1;
            return e;
        end
        e.mem  = 1'b1;
        e.addr = res - 32'(off);
        span   = longint'(1) << (8 * size);
        if (op == STORE) begin
            e.wen   = 1'b1;
            e.data  = res;
            e.wstrb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(rs2 >> (8 * (i % size)));
        end else begin
            v = longint'(rdata >> (8 * off)) % span;
            if (!f3[2] && size < 4 && v >= span / 2) v = v - span;
            e.data = 32'(v);
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                                input logic [31:0] rs2, input logic [31:0] rdata, input int dr,
                                input logic mem, input logic wen, input logic [31:0] addr,
                                input logic [3:0] wstrb, input logic [31:0] wdata,
                                input logic [31:0] data, input logic fault);
        vec_t v;
        v.op = op; v.f3 = f3; v.res = res; v.rs2 = rs2; v.rdata = rdata; v.dr = dr;
        v.e.mem = mem; v.e.wen = wen; v.e.addr = addr; v.e.wstrb = wstrb;
        v.e.wdata = wdata; v.e.data = data; v.e.fault = fault;
        return v;
    endfunction

    // Issue one instruction from IDLE, act as memory and write-back, record what the DUT did.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] rs2, input logic [31:0] rdata,
                       input int dr, input int dv, input int dl, output obs_t o);
        int lsu_cnt = 0;
        int rd_wait = 0;
        bit rd_armed = 0;
        o = '{default: 0};
        o.req_stable = 1;
        o.lsu_stable = 1;
        @(negedge clk);
        exe_opcode = op; exe_func3 = f3; exe_reg_addr = rd;
        exe_result = res; exe_rs2 = rs2; exe_valid = 1'b1;
        check("exe_ready_idle", 32'(exe_ready), 32'd1);
        for (int cyc = 1; cyc <= 60 && !o.done; cyc++) begin
            @(negedge clk);
            exe_valid = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; lsu_ready = 1'b0;
            if (rd_armed) begin
                if (rd_wait == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                    rd_armed    = 0;
                end else rd_wait--;
            end
            if (dmem_valid) begin
                if (!o.req_seen) begin
                    o.req_seen = 1; o.req_cyc = cyc; o.wen = dmem_wen;
                    o.addr = dmem_addr; o.wstrb = dmem_wstrb; o.wdata = dmem_wdata;
                end else if (dmem_wen !== o.wen || dmem_addr !== o.addr ||
                             dmem_wstrb !== o.wstrb || dmem_wdata !== o.wdata) begin
                    o.req_stable = 0;
                end
                o.req_cnt++;
                if (o.req_cnt > dr) begin
                    dmem_ready = 1'b1;
                    if (!dmem_wen) begin
                        rd_armed = 1;
                        rd_wait  = dv;
                    end
                end
            end
            if (lsu_valid) begin
                if (!o.lsu_seen) begin
                    o.lsu_seen = 1; o.lsu_cyc = cyc; o.op = lsu_opcode; o.rd = lsu_reg_addr;
                    o.mem_addr = lsu_mem_addr; o.data = lsu_data; o.fault = lsu_fault;
                end else if (lsu_opcode !== o.op || lsu_reg_addr !== o.rd ||
                             lsu_mem_addr !== o.mem_addr || lsu_data !== o.data ||
                             lsu_fault !== o.fault) begin
                    o.lsu_stable = 0;
                end
                // Stray read responses while holding the result must be ignored
                if (!dmem_rvalid) begin
                    dmem_rvalid = 1'($urandom % 2);
                    dmem_rdata  = $urandom;
                end
                lsu_cnt++;
                if (lsu_cnt > dl) begin
                    lsu_ready = 1'b1;
                    o.done    = 1;
                end
            end
        end
        @(negedge clk);
        lsu_ready = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic verify(input string tag, input obs_t o, input exp_t e, input logic [6:0] op,
                          input logic [4:0] rd, input logic [31:0] res, input int dr, input int dv);
        int lat;
        check({tag, ".done"}, 32'(o.done), 32'd1);
        check({tag, ".req"}, 32'(o.req_seen), 32'(e.mem));
        if (e.mem) begin
            check({tag, ".addr"}, o.addr, e.addr);
            check({tag, ".wen"}, 32'(o.wen), 32'(e.wen));
            check({tag, ".wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
            if (e.wen) check({tag, ".wdata"}, o.wdata, e.wdata);
            check({tag, ".req_cyc"}, 32'(o.req_cyc), 32'd1);
            check({tag, ".req_len"}, 32'(o.req_cnt), 32'(dr + 1));
            check({tag, ".req_stable"}, 32'(o.req_stable), 32'd1);
        end
        lat = !e.mem ? 1 : e.wen ? dr + 2 : dr + dv + 3;
        check({tag, ".lat"}, 32'(o.lsu_cyc), 32'(lat));
        check({tag, ".data"}, o.data, e.data);
        check({tag, ".fault"}, 32'(o.fault), 32'(e.fault));
        check({tag, ".rd_op"}, {20'd0, o.op, o.rd}, {20'd0, op, rd});
        check({tag, ".mem_addr"}, o.mem_addr, res);
        check({tag, ".lsu_stable"}, 32'(o.lsu_stable), 32'd1);
    endtask

    task automatic recover_if_hung(input obs_t o);
        if (!o.done) begin
            @(negedge clk); nrst = 1'b0;
            @(negedge clk); nrst = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[$];
        obs_t  o;
        exp_t  e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int dr, dv, dl;

        tbl.push_back(mk(LOAD,   3'b000, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 0, 1, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 0));
        tbl.push_back(mk(LOAD,   3'b100, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1, 1, 0, 32'h100, 4'h0, 32'h0, 32'h0000_0080, 0));
        tbl.push_back(mk(LOAD,   3'b001, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 0, 1, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_80FF, 0));
        tbl.push_back(mk(LOAD,   3'b101, 32'h0000_0100, 32'h0, 32'h80FF_7F01, 2, 1, 0, 32'h100, 4'h0, 32'h0, 32'h0000_7F01, 0));
        tbl.push_back(mk(LOAD,   3'b010, 32'h0000_0104, 32'h0, 32'h80FF_7F01, 0, 1, 0, 32'h104, 4'h0, 32'h0, 32'h80FF_7F01, 0));
        tbl.push_back(mk(LOAD,   3'b000, 32'h7FFF_FFFF, 32'h0, 32'h7F00_0000, 0, 1, 0, 32'h7FFF_FFFC, 4'h0, 32'h0, 32'h0000_007F, 0));
        tbl.push_back(mk(LOAD,   3'b001, 32'h0000_0002, 32'h0, 32'h8000_1234, 1, 1, 0, 32'h0, 4'h0, 32'h0, 32'hFFFF_8000, 0));
        tbl.push_back(mk(STORE,  3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 3, 1, 1, 32'h2000, 4'hC, 32'hBEEF_BEEF, 32'h0000_2002, 0));
        tbl.push_back(mk(STORE,  3'b000, 32'h0000_0011, 32'h1234_5678, 32'h0, 0, 1, 1, 32'h10, 4'h2, 32'h7878_7878, 32'h0000_0011, 0));
        tbl.push_back(mk(STORE,  3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 1, 1, 1, 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0000_0020, 0));
        tbl.push_back(mk(LOAD,   3'b010, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(LOAD,   3'b001, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(LOAD,   3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(STORE,  3'b001, 32'h0000_0005, 32'h1111_2222, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(OP_IMM, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 0));

        // Reset, then a stray rvalid in IDLE
        repeat (2) @(negedge clk);
        check("rst_ctrl", {23'd0, dmem_valid, dmem_wen, lsu_valid, lsu_fault, dmem_wstrb, exe_ready}, 32'd1);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_lsu_data", lsu_data, 32'd0);
        check("rst_lsu_mem_addr", lsu_mem_addr, 32'd0);
        check("rst_lsu_op_rd", {20'd0, lsu_opcode, lsu_reg_addr}, 32'd0);
        nrst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("idle_rvalid", {30'd0, lsu_valid, dmem_valid}, 32'd0);
        @(negedge clk);
        check("idle_rvalid2", 32'(lsu_valid), 32'd0);

        // Back-to-back pass-through
        exe_opcode = OP_IMM; exe_func3 = 3'b000; exe_reg_addr = 5'd5;
        exe_result = 32'h1234_5678; exe_valid = 1'b1; lsu_ready = 1'b1;
        @(negedge clk);
        check("b2b_first", {lsu_valid, exe_ready, 25'd0, lsu_reg_addr}, {1'b1, 1'b1, 25'd0, 5'd5});
        check("b2b_first_data", lsu_data, 32'h1234_5678);
        exe_opcode = LUI; exe_reg_addr = 5'd6; exe_result = 32'hABCD_0000;
        @(negedge clk);
        check("b2b_second", {lsu_valid, exe_ready, 18'd0, lsu_opcode, lsu_reg_addr}, {1'b1, 1'b1, 18'd0, LUI, 5'd6});
        check("b2b_second_data", lsu_data, 32'hABCD_0000);
        exe_valid = 1'b0;
        @(negedge clk);
        check("b2b_drain", 32'(lsu_valid), 32'd0);
        lsu_ready = 1'b0;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            rd = 5'(i + 1);
            dl = i % 3;
            run(tbl[i].op, tbl[i].f3, rd, tbl[i].res, tbl[i].rs2, tbl[i].rdata, tbl[i].dr, 1, dl, o);
            verify($sformatf("tbl%0d", i), o, tbl[i].e, tbl[i].op, rd, tbl[i].res, tbl[i].dr, 1);
            recover_if_hung(o);
        end

        // Randomized instructions against the model
        for (int i = 0; i < 150; i++) begin
            case ($urandom % 6)
                0, 1:    op = LOAD;
                2, 3:    op = STORE;
                4:       op = OP;
                default: op = ($urandom % 2) ? LUI : OP_IMM;
            endcase
            f3 = 3'($urandom % 8);
            res = $urandom; rs2 = $urandom; rdata = $urandom; rd = 5'($urandom);
            dr = $urandom_range(0, 3); dv = $urandom_range(0, 3); dl = $urandom_range(0, 2);
            e = model(op, f3, res, rs2, rdata);
            run(op, f3, rd, res, rs2, rdata, dr, dv, dl, o);
            verify($sformatf("rnd%0d", i), o, e, op, rd, res, dr, dv);
            recover_if_hung(o);
        end

        // LW held under write-back backpressure
        run(LOAD, 3'b010, 5'd7, 32'h40, 32'h0, 32'h55AA_33CC, 0, 0, 4, o);
        e = model(LOAD, 3'b010, 32'h40, 32'h0, 32'h55AA_33CC);
        verify("bp_lw", o, e, LOAD, 5'd7, 32'h40, 0, 0);
        recover_if_hung(o);

        // Second LW abandoned by reset while waiting for data; late rvalid is ignored
        @(negedge clk);
        exe_opcode = LOAD; exe_func3 = 3'b010; exe_reg_addr = 5'd8;
        exe_result = 32'h44; exe_valid = 1'b1;
        @(negedge clk);
        exe_valid = 1'b0;
        check("rst_lw_req", {31'd0, dmem_valid}, 32'd1);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("rst_lw_wait", {29'd0, dmem_valid, lsu_valid, exe_ready}, 32'd0);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("rst_lw_after", {29'd0, dmem_valid, lsu_valid, exe_ready}, 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("late_rvalid", {30'd0, lsu_valid, exe_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("late_rvalid_quiet", {30'd0, lsu_valid, dmem_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/riscv32ima_lsu.md
# riscv32ima_lsu

Load/store stage of the riscv32ima pipeline, between execute and write-back. It takes one decoded instruction at a time from execute and runs the data-memory access for LOAD and STORE. It aligns and extends load data and forms byte strobes for stores. Each completed instruction goes to write-back on the lsu_* valid/ready channel; every other opcode passes through unchanged apart from one register stage.

## Interface
- ADDR_WIDTH, 32, memory address width
- REG_ADDR_WIDTH, 5, register index width
- REG_DATA_WIDTH, 32, register/data width (fixed at 32; byte-lane logic assumes 4 lanes)
- OPCODE_WIDTH, 7, RISC-V major opcode width
- FUNC3_WIDTH, 3, funct3 width
- LOAD, 7'b0000011 / STORE, 7'b0100011, opcode encodings handled here

Ports:
- clk  in  1  clock; all logic rising-edge
- nrst  in  1  reset, synchronous, active-low
- exe_valid  in  1  execute has an instruction
- exe_ready  out  1  LSU accepts it this cycle
- exe_opcode  in  7  major opcode
- exe_func3  in  3  width/sign select
- exe_reg_addr  in  5  rd
- exe_result  in  32  ALU result; effective address for LOAD/STORE
- exe_rs2  in  32  store data
- dmem_valid  out  1  memory request
- dmem_ready  in  1  request accepted
- dmem_wen  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wstrb  out  4  byte enables (0 for reads)
- dmem_wdata  out  32  lane-replicated store data
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- lsu_valid  out  1  result to write-back
- lsu_ready  in  1  write-back accepts
- lsu_opcode  out  7  opcode of the result
- lsu_reg_addr  out  5  rd
- lsu_mem_addr  out  32  full effective address / exe_result
- lsu_data  out  32  load data, or exe_result for non-loads
- lsu_fault  out  1  misaligned access; qualified by lsu_valid

## Operation
- States: IDLE, REQ, WAIT, OUT.
- Accept condition: exe_valid && exe_ready.
- exe_ready = (state==IDLE) || (state==OUT && lsu_ready).
- On accept, latch opcode, func3, rd, exe_result and exe_rs2. Next state depends on the opcode:
  - LOAD/STORE, aligned → REQ.
  - LOAD/STORE, misaligned → OUT with lsu_fault=1 and lsu_data=0; no memory access.
  - Any other opcode → OUT with lsu_data=exe_result.
- Alignment rules:
  - func3[1:0]=00 (byte) is always aligned.
  - 01 (half) needs addr[0]=0.
  - 10 (word) needs addr[1:0]=0.
  - 11 counts as misaligned.
- REQ:
  - dmem_valid=1; dmem_wen=1 for STORE.
  - Request fields stay stable until dmem_ready.
  - On dmem_ready, STORE → OUT and LOAD → WAIT.
- WAIT: on dmem_rvalid, select the lane by addr[1:0] and go to OUT.
  - func3 000/100: byte, sign- or zero-extended.
  - func3 001/101: half, sign- or zero-extended.
  - func3 010: word.
- OUT:
  - lsu_valid=1; all lsu_* fields are held stable until lsu_ready.
  - On lsu_ready: if exe_valid in the same cycle, accept it (same next-state rules); else → IDLE.
- Store strobes and data:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = rs2.
- Store result: lsu_data = exe_result (write-back ignores it).
- dmem_rvalid outside WAIT is ignored.

## Timing
- Reset (nrst=0 at a clock edge):
  - State becomes IDLE.
  - lsu_valid, dmem_valid, dmem_wen, lsu_fault and dmem_wstrb become 0.
  - All data/address outputs become 0.
- Reset mid-operation abandons the instruction: dmem_valid drops the next cycle. An rvalid still in flight after reset is ignored.
- Latency, with the instruction accepted at cycle N:
  - Pass-through or fault: lsu_valid at N+1.
  - STORE: dmem_valid at N+1. If dmem_ready is high at N+1, lsu_valid at N+2.
  - LOAD: dmem_valid at N+1, then rvalid at cycle R (R ≥ N+2), then lsu_valid at R+1.
- Throughput:
  - Pass-through: one instruction per cycle while lsu_ready=1, via the back-to-back accept in OUT.
  - Memory ops: at most one outstanding request.
- dmem_valid never drops before dmem_ready; lsu_valid never drops before lsu_ready.

## Test plan
- Reset then idle: hold nrst=0 for 2 cycles → all outputs 0 and exe_ready=1. Release, and issue rvalid=1 in IDLE → no lsu_valid.
- Pass-through stream: OP_IMM with result 0x12345678, rd=5, lsu_ready=1, followed back-to-back by LUI with result 0xABCD0000 → lsu_valid in two consecutive cycles with the matching data/rd, and exe_ready stays high.
- LB/LBU: addr 0x103 with rdata 0x80FF7F01 → LB gives lsu_data=0xFFFFFF80; LBU gives 0x00000080. dmem_addr=0x100 and wstrb=0.
- SH at addr 0x2002 with rs2=0xDEADBEEF, dmem_ready held low for 3 cycles → request fields stable throughout, wstrb=4'b1100, wdata=0xBEEFBEEF; lsu_valid appears one cycle after dmem_ready.
- Misaligned LW at 0x0001 → no dmem_valid; at N+1, lsu_valid=1, lsu_fault=1, lsu_data=0.
- Backpressure plus reset: LW completes with lsu_ready=0 for 4 cycles → outputs held. A second LW is accepted, then nrst=0 while it is in WAIT → the FSM returns to IDLE and a late rvalid produces no output.
